// File: rtl/axi5_xlat_read_sub.sv
// AXI5 read-only subordinate with untranslated-transaction stream-ID checking.
// Terminates AR/R. Each burst is classified once, at AR acceptance. The burst is
// then served one beat every two cycles (FETCH then DATA) from a local word memory,
// or it returns an error response with zero data.
module axi5_xlat_read_sub #(
  parameter int unsigned                    ADDR_WIDTH = 16,
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    ID_WIDTH   = 4,
  parameter int unsigned                    SID_WIDTH  = 3,
  parameter int unsigned                    SSID_WIDTH = 6,
  parameter int unsigned                    MEM_WORDS  = 1024,
  parameter logic [(1<<SID_WIDTH)-1:0]      SID_ALLOW  = 8'hFF,
  parameter int unsigned                    MAX_SSID   = 63,
  parameter bit                             SEC_ALLOW  = 1'b1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          arvalid,
  output logic                          arready,
  input  logic [ID_WIDTH-1:0]           arid,
  input  logic [ADDR_WIDTH-1:0]         araddr,
  input  logic [7:0]                    arlen,
  input  logic [2:0]                    arsize,
  input  logic [1:0]                    arburst,
  input  logic                          armmuvalid,
  input  logic                          armmusecsid,
  input  logic [SID_WIDTH-1:0]          armmusid,
  input  logic                          armmussidv,
  input  logic [SSID_WIDTH-1:0]         armmussid,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [ID_WIDTH-1:0]           rid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [2:0]                    rresp,
  output logic                          rlast,
  input  logic                          pl_we,
  input  logic [$clog2(MEM_WORDS)-1:0]  pl_addr,
  input  logic [DATA_WIDTH-1:0]         pl_data,
  output logic [15:0]                   fault_count
);

  localparam int unsigned LSB   = $clog2(DATA_WIDTH / 8);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  localparam logic [2:0] RespOkay       = 3'b000;
  localparam logic [2:0] RespSlvErr     = 3'b010;
  localparam logic [2:0] RespDecErr     = 3'b011;
  localparam logic [2:0] RespTransFault = 3'b101;

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  state_e                  state_q;
  logic                    arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]     rid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [2:0]              rresp_q, cls_q;
  logic [15:0]             fault_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q, beat_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;

  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic                    sid_fault, slv_fault, dec_fault;
  logic [31:0]             start_word;
  logic [2:0]              ar_cls;
  logic [ADDR_WIDTH-1:0]   step, wrap_mask, addr_nxt;
  logic [IDX_W-1:0]        mem_idx;

  assign arready     = arready_q;
  assign rvalid      = rvalid_q;
  assign rid         = rid_q;
  assign rdata       = rdata_q;
  assign rresp       = rresp_q;
  assign rlast       = rlast_q;
  assign fault_count = fault_cnt_q;

  // Beat word index: the top of memory wraps to word 0.
  assign mem_idx = addr_q[LSB +: IDX_W];

  // Classify the incoming AR request; first match wins.
  always_comb begin
    start_word = 32'(araddr) >> LSB;
    sid_fault  = armmuvalid &&
                 (!SID_ALLOW[armmusid] ||
                  (armmussidv && (32'(armmussid) > MAX_SSID)) ||
                  (armmusecsid && !SEC_ALLOW));
    slv_fault  = (32'(arsize) > LSB) || (arburst == 2'b11) ||
                 ((arburst == 2'b10) &&
                  !((arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15)));
    dec_fault  = start_word >= MEM_WORDS;
    if (sid_fault)      ar_cls = RespTransFault;
    else if (slv_fault) ar_cls = RespSlvErr;
    else if (dec_fault) ar_cls = RespDecErr;
    else                ar_cls = RespOkay;
  end

  // Next beat address for FIXED / INCR / WRAP bursts.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_nxt = addr_q + step;
    endcase
  end

  // Preload port; not reset. A read of the same word in this cycle sees the old data.
  always_ff @(posedge aclk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
  end

  // Request/response FSM with registered channel outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      arready_q   <= 1'b1;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      cls_q       <= '0;
      fault_cnt_q <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      size_q      <= '0;
      burst_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arvalid) begin
            rid_q     <= arid;
            addr_q    <= araddr;
            len_q     <= arlen;
            size_q    <= arsize;
            burst_q   <= arburst;
            cls_q     <= ar_cls;
            beat_q    <= '0;
            arready_q <= 1'b0;
            state_q   <= StFetch;
            if (ar_cls == RespTransFault && fault_cnt_q != 16'hFFFF) begin
              fault_cnt_q <= fault_cnt_q + 16'd1;
            end
          end
        end
        StFetch: begin
          rdata_q  <= (cls_q == RespOkay) ? mem[mem_idx] : '0;
          rresp_q  <= cls_q;
          rlast_q  <= (beat_q == len_q);
          rvalid_q <= 1'b1;
          state_q  <= StData;
        end
        StData: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              state_q   <= StIdle;
            end else begin
              addr_q  <= addr_nxt;
              beat_q  <= beat_q + 8'd1;
              state_q <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
